task_cfg_monitor: RTL and testbench

//   Synthesizable run-time successor to the top-level formal register checks, generalised to N task channels
//   (pb0, pb1, pp, ...). Per channel it compares the live register config against the expected config at start,

---
 rtl/task_mon_pkg.sv | 19 +
 rtl/task_ch_monitor.sv | 114 +++++++++++
 rtl/task_cfg_monitor.sv | 116 +++++++++++
 tb/tb_task_cfg_monitor.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/task_mon_pkg.sv
// Shared types for the task config/protocol monitor.
// Latency: n/a (types only).
// Backpressure: n/a.
package task_mon_pkg;

  typedef enum logic {
    MON_IDLE = 1'b0,
    MON_RUN  = 1'b1
  } mon_state_t;

  typedef struct packed {
    logic cfg_err;
    logic proto_err;
    logic timeout;
  } mon_err_t;

  localparam int MON_ERR_W = $bits(mon_err_t);

endpackage

// File: rtl/task_ch_monitor.sv
// One task channel: start/busy/irq protocol FSM, RUN timer, masked cfg compare, done counter, sticky errors.
// Latency: sticky errors and done count update one cycle after the sampled input cycle.
// Backpressure: none; passive observer, never stalls the task it watches.
//
// Ports:
//   clk, reset          clock, async active-low reset
//   start_i/busy_i/irq_i task handshake of this channel
//   cfg_i, exp_cfg_i    live and expected config, compared under CFG_MASK at start
//   timeout_i           max RUN cycles, 0 disables
//   clr_i               clears this channel's sticky errors
//   err_o               sticky error bits
//   err_set_o           errors raised by the current input cycle (combinational, for rise detection)
//   done_cnt_o          saturating completed-task count
module task_ch_monitor
  import task_mon_pkg::*;
#(
  parameter int              CFG_W    = 64,
  parameter logic [CFG_W-1:0] CFG_MASK = '1,
  parameter int              TO_W     = 16,
  parameter int              CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             busy_i,
  input  logic             irq_i,
  input  logic [CFG_W-1:0] cfg_i,
  input  logic [CFG_W-1:0] exp_cfg_i,
  input  logic [TO_W-1:0]  timeout_i,
  input  logic             clr_i,
  output mon_err_t         err_o,
  output mon_err_t         err_set_o,
  output logic [CNT_W-1:0] done_cnt_o
);

  mon_state_t       state_q, state_d;
  logic [TO_W-1:0]  timer_q, timer_d;
  logic [CNT_W-1:0] done_q, done_d;
  mon_err_t         err_q, err_set;

  logic             cfg_mismatch;
  logic             to_hit;
  logic [TO_W-1:0]  timer_inc;
  logic [CNT_W-1:0] done_inc;

  assign cfg_mismatch = |((cfg_i ^ exp_cfg_i) & CFG_MASK);
  // Last permitted RUN cycle: timer counts 0..timeout_i-1.
  assign to_hit       = (timeout_i != '0) && (timer_q == (timeout_i - TO_W'(1)));
  // Both saturate; with a nonzero timeout the timer never gets near the top.
  assign timer_inc    = (&timer_q) ? timer_q : timer_q + TO_W'(1);
  assign done_inc     = (&done_q)  ? done_q  : done_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    done_d  = done_q;
    err_set = '0;
    if (state_q == MON_IDLE) begin
      if (irq_i) begin
        err_set.proto_err = 1'b1;
      end
      if (start_i) begin
        err_set.cfg_err = cfg_mismatch;
        state_d         = MON_RUN;
        timer_d         = '0;
      end
    end else begin
      if (start_i) begin
        // Restart: with irq it is a legal back-to-back task, without it the old task was abandoned.
        err_set.cfg_err = cfg_mismatch;
        timer_d         = '0;
        if (irq_i) begin
          done_d = done_inc;
        end else begin
          err_set.proto_err = 1'b1;
        end
      end else if (irq_i) begin
        done_d  = done_inc;
        state_d = MON_IDLE;
      end else begin
        // timer == 0 is the cycle right after start, where busy may still be rising.
        if ((timer_q != '0) && !busy_i) begin
          err_set.proto_err = 1'b1;
        end
        if (to_hit) begin
          err_set.timeout = 1'b1;
          state_d         = MON_IDLE;
        end else begin
          timer_d = timer_inc;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= MON_IDLE;
      timer_q <= '0;
      done_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      done_q  <= done_d;
      // A new error in the same cycle as a clear wins.
      err_q   <= mon_err_t'(err_set | (err_q & ~{MON_ERR_W{clr_i}}));
    end
  end

  assign err_o      = err_q;
  assign err_set_o  = err_set;
  assign done_cnt_o = done_q;

endmodule

// File: rtl/task_cfg_monitor.sv
// N-channel task monitor: per-channel cfg/protocol/timeout checks, summary irq and first-error record.
// Latency: errors, err_irq_o and first-error record appear one cycle after the offending input cycle.
// Backpressure: none; purely observes the register block and task handshakes.
//
// Ports:
//   clk, reset              clock, async active-low reset
//   start_i/busy_i/irq_i    per-channel task handshake
//   cfg_i, exp_cfg_i        per-channel live/expected config, channel c at [c*CFG_W +: CFG_W]
//   timeout_i               max RUN cycles per task, 0 disables
//   clr_i                   per-channel sticky error clear
//   cfg_err_o/proto_err_o/timeout_o  per-channel sticky errors
//   done_cnt_o              per-channel saturating done counts, channel c at [c*CNT_W +: CNT_W]
//   err_valid_o, err_ch_o   first-error record
//   err_irq_o               pulse when any sticky bit rises
module task_cfg_monitor
  import task_mon_pkg::*;
#(
  parameter int               N_CH     = 3,
  parameter int               CFG_W    = 64,
  parameter logic [CFG_W-1:0] CFG_MASK = '1,
  parameter int               TO_W     = 16,
  parameter int               CNT_W    = 8,
  localparam int              CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CH-1:0]       start_i,
  input  logic [N_CH-1:0]       busy_i,
  input  logic [N_CH-1:0]       irq_i,
  input  logic [N_CH*CFG_W-1:0] cfg_i,
  input  logic [N_CH*CFG_W-1:0] exp_cfg_i,
  input  logic [TO_W-1:0]       timeout_i,
  input  logic [N_CH-1:0]       clr_i,
  output logic [N_CH-1:0]       cfg_err_o,
  output logic [N_CH-1:0]       proto_err_o,
  output logic [N_CH-1:0]       timeout_o,
  output logic [N_CH*CNT_W-1:0] done_cnt_o,
  output logic                  err_valid_o,
  output logic [CH_W-1:0]       err_ch_o,
  output logic                  err_irq_o
);

  mon_err_t ch_err [N_CH];
  mon_err_t ch_set [N_CH];

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    task_ch_monitor #(
      .CFG_W    (CFG_W),
      .CFG_MASK (CFG_MASK),
      .TO_W     (TO_W),
      .CNT_W    (CNT_W)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .start_i    (start_i[c]),
      .busy_i     (busy_i[c]),
      .irq_i      (irq_i[c]),
      .cfg_i      (cfg_i[c*CFG_W +: CFG_W]),
      .exp_cfg_i  (exp_cfg_i[c*CFG_W +: CFG_W]),
      .timeout_i  (timeout_i),
      .clr_i      (clr_i[c]),
      .err_o      (ch_err[c]),
      .err_set_o  (ch_set[c]),
      .done_cnt_o (done_cnt_o[c*CNT_W +: CNT_W])
    );

    assign cfg_err_o[c]   = ch_err[c].cfg_err;
    assign proto_err_o[c] = ch_err[c].proto_err;
    assign timeout_o[c]   = ch_err[c].timeout;
  end

  logic            any_rise;
  logic [N_CH-1:0] ch_hit;
  logic [CH_W-1:0] first_ch;
  logic            any_sticky;
  logic            rec_free;

  always_comb begin
    any_rise = 1'b0;
    ch_hit   = '0;
    first_ch = '0;
    for (int c = 0; c < N_CH; c++) begin
      // Only bits currently at 0 count as a rise; re-setting a 1 is silent.
      any_rise  = any_rise | (|(ch_set[c] & ~ch_err[c]));
      ch_hit[c] = |ch_set[c];
    end
    // Descending scan so the lowest channel is the last to write.
    for (int c = N_CH - 1; c >= 0; c--) begin
      if (ch_hit[c]) begin
        first_ch = CH_W'(c);
      end
    end
  end

  assign any_sticky = |{cfg_err_o, proto_err_o, timeout_o};
  // A record whose errors are all cleared is retired this cycle, so a new error here may claim it.
  assign rec_free   = !err_valid_o || !any_sticky;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_valid_o <= 1'b0;
      err_ch_o    <= '0;
      err_irq_o   <= 1'b0;
    end else begin
      err_irq_o <= any_rise;
      if (rec_free && (|ch_hit)) begin
        err_valid_o <= 1'b1;
        err_ch_o    <= first_ch;
      end else if (!any_sticky) begin
        err_valid_o <= 1'b0;
        err_ch_o    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_task_cfg_monitor.sv
// Bench for task_cfg_monitor: two instances (full mask / 8-bit counters, bit 3 masked off / 2-bit counters)
// driven by the same stimulus and checked every cycle against a behavioural task model.
// Directed scenarios first, then randomized traffic with occasional resets.
module tb_task_cfg_monitor;

  logic         clk;
  logic         reset;
  logic [2:0]   start, busy, irq, clr;
  logic [191:0] cfg, exp_cfg;
  logic [15:0]  timeout;

  logic [2:0]   cfg_err_a, proto_err_a, timeout_a;
  logic [23:0]  done_a;
  logic         valid_a, irq_a;
  logic [1:0]   ch_a;
  logic [2:0]   cfg_err_b, proto_err_b, timeout_b;
  logic [5:0]   done_b;
  logic         valid_b, irq_b;
  logic [1:0]   ch_b;

  task_cfg_monitor #(.N_CH(3), .CFG_W(64), .CFG_MASK('1), .TO_W(16), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .start_i(start), .busy_i(busy), .irq_i(irq),
    .cfg_i(cfg), .exp_cfg_i(exp_cfg), .timeout_i(timeout), .clr_i(clr),
    .cfg_err_o(cfg_err_a), .proto_err_o(proto_err_a), .timeout_o(timeout_a),
    .done_cnt_o(done_a), .err_valid_o(valid_a), .err_ch_o(ch_a), .err_irq_o(irq_a));

  task_cfg_monitor #(.N_CH(3), .CFG_W(64), .CFG_MASK(64'hFFFF_FFFF_FFFF_FFF7), .TO_W(16), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .start_i(start), .busy_i(busy), .irq_i(irq),
    .cfg_i(cfg), .exp_cfg_i(exp_cfg), .timeout_i(timeout), .clr_i(clr),
    .cfg_err_o(cfg_err_b), .proto_err_o(proto_err_b), .timeout_o(timeout_b),
    .done_cnt_o(done_b), .err_valid_o(valid_b), .err_ch_o(ch_b), .err_irq_o(irq_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  // Per instance: is a task in flight, how many cycles it has run, tasks done, sticky flags, record.
  bit          m_run  [2][3];
  int          m_age  [2][3];
  int          m_done [2][3];
  bit [2:0]    m_ecfg [2];
  bit [2:0]    m_eprot[2];
  bit [2:0]    m_etmo [2];
  bit          m_v    [2];
  int          m_ch   [2];
  bit          m_irq  [2];

  function automatic logic [63:0] mask_of(input int m);
    return (m == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFF7;
  endfunction

  function automatic int cmax_of(input int m);
    return (m == 0) ? 255 : 3;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int c = 0; c < 3; c++) begin
        m_run[m][c] = 0; m_age[m][c] = 0; m_done[m][c] = 0;
      end
      m_ecfg[m] = 0; m_eprot[m] = 0; m_etmo[m] = 0;
      m_v[m] = 0; m_ch[m] = 0; m_irq[m] = 0;
    end
  endtask

  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      bit [2:0] nc, np, nt;
      bit       old_any, new_any;
      int       low;
      nc = 0; np = 0; nt = 0;
      for (int c = 0; c < 3; c++) begin
        bit mis;
        mis = (((cfg[c*64 +: 64] ^ exp_cfg[c*64 +: 64]) & mask_of(m)) != 64'd0);
        if (start[c]) nc[c] = mis;
        if (!m_run[m][c]) begin
          if (irq[c]) np[c] = 1;
          if (start[c]) begin m_run[m][c] = 1; m_age[m][c] = 0; end
        end else if (start[c] || irq[c]) begin
          if (irq[c]) m_done[m][c] = (m_done[m][c] < cmax_of(m)) ? m_done[m][c] + 1 : m_done[m][c];
          if (start[c] && !irq[c]) np[c] = 1;
          if (start[c]) m_age[m][c] = 0;
          else m_run[m][c] = 0;
        end else begin
          if (m_age[m][c] > 0 && !busy[c]) np[c] = 1;
          if (timeout != 0 && m_age[m][c] == int'(timeout) - 1) begin
            nt[c] = 1; m_run[m][c] = 0;
          end else if (m_age[m][c] < 65535) begin
            m_age[m][c]++;
          end
        end
      end
      old_any = (m_ecfg[m] | m_eprot[m] | m_etmo[m]) != 0;
      new_any = (nc | np | nt) != 0;
      low = 0;
      for (int c = 2; c >= 0; c--) if ((nc[c] | np[c] | nt[c]) != 0) low = c;
      m_irq[m] = ((nc & ~m_ecfg[m]) | (np & ~m_eprot[m]) | (nt & ~m_etmo[m])) != 0;
      if ((!m_v[m] || !old_any) && new_any) begin
        m_v[m] = 1; m_ch[m] = low;
      end else if (!old_any) begin
        m_v[m] = 0; m_ch[m] = 0;
      end
      m_ecfg[m]  = nc | (m_ecfg[m]  & ~clr);
      m_eprot[m] = np | (m_eprot[m] & ~clr);
      m_etmo[m]  = nt | (m_etmo[m]  & ~clr);
    end
  endtask

  task automatic chk_inst(input int m, input logic [2:0] ce, input logic [2:0] pe, input logic [2:0] te,
                          input logic [23:0] dc, input logic v, input logic [1:0] ch, input logic ir);
    string p;
    int    w;
    p = (m == 0) ? "a" : "b";
    w = (m == 0) ? 8 : 2;
    chk({p, "_cfg_err"},   32'(ce), 32'(m_ecfg[m]));
    chk({p, "_proto_err"}, 32'(pe), 32'(m_eprot[m]));
    chk({p, "_timeout"},   32'(te), 32'(m_etmo[m]));
    for (int c = 0; c < 3; c++)
      chk($sformatf("%s_done%0d", p, c), 32'((dc >> (c * w)) & ((24'd1 << w) - 24'd1)), 32'(m_done[m][c]));
    chk({p, "_err_valid"}, 32'(v),  32'(m_v[m]));
    chk({p, "_err_ch"},    32'(ch), 32'(m_ch[m]));
    chk({p, "_err_irq"},   32'(ir), 32'(m_irq[m]));
  endtask

  task automatic check_all();
    chk_inst(0, cfg_err_a, proto_err_a, timeout_a, done_a, valid_a, ch_a, irq_a);
    chk_inst(1, cfg_err_b, proto_err_b, timeout_b, {18'd0, done_b}, valid_b, ch_b, irq_b);
  endtask

  // One clock: apply pulses, advance model, sample 1 time unit after the edge.
  task automatic cyc(input logic [2:0] s, input logic [2:0] i, input logic [2:0] cl);
    start = s; irq = i; clr = cl;
    model_step();
    @(posedge clk);
    #1;
    check_all();
    start = 0; irq = 0; clr = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic rand_cfg();
    for (int w = 0; w < 6; w++) cfg[w*32 +: 32] = $urandom();
    exp_cfg = cfg;
  endtask

  initial begin
    int rc, rb;
    logic [2:0] rs, ri, rl;
    reset = 1'b0; start = 0; busy = 3'b111; irq = 0; clr = 0; timeout = 0;
    rand_cfg();
    do_reset();

    // 1: clean task on ch0
    cyc(3'b001, 0, 0);
    for (int k = 0; k < 5; k++) cyc(0, 0, 0);
    cyc(0, 3'b001, 0);
    chk("t1_done0", 32'(done_a[7:0]), 32'd1);
    chk("t1_no_err", 32'({cfg_err_a, proto_err_a, timeout_a}), 32'd0);

    // 2: cfg bit 3 differs on ch1; only instance a compares bit 3
    exp_cfg[64 + 3] = ~exp_cfg[64 + 3];
    cyc(3'b010, 0, 0);
    chk("t2_cfg_err_a", 32'(cfg_err_a), 32'b010);
    chk("t2_irq_a", 32'(irq_a), 32'd1);
    chk("t2_valid_a", 32'(valid_a), 32'd1);
    chk("t2_ch_a", 32'(ch_a), 32'd1);
    chk("t2_cfg_err_b", 32'(cfg_err_b), 32'd0);
    exp_cfg = cfg;
    cyc(0, 3'b010, 0);
    cyc(0, 0, 3'b010);
    cyc(0, 0, 0);
    chk("t2_valid_cleared", 32'(valid_a), 32'd0);

    // 3: timeout on ch2
    timeout = 16'd10;
    cyc(3'b100, 0, 0);
    for (int k = 1; k <= 10; k++) begin
      cyc(0, 0, 0);
      chk($sformatf("t3_timeout_k%0d", k), 32'(timeout_a[2]), (k == 10) ? 32'd1 : 32'd0);
    end
    cyc(0, 3'b100, 0);
    chk("t3_late_irq", 32'(proto_err_a[2]), 32'd1);
    timeout = 0;

    // 4: back-to-back start+irq on ch0
    do_reset();
    cyc(3'b001, 0, 0);
    for (int k = 0; k < 4; k++) cyc(3'b001, 3'b001, 0);
    chk("t4_done4", 32'(done_a[7:0]), 32'd4);
    chk("t4_no_proto", 32'(proto_err_a), 32'd0);
    cyc(3'b001, 0, 0);
    chk("t4_restart_proto", 32'(proto_err_a[0]), 32'd1);

    // 5: simultaneous errors, clear racing a new error
    do_reset();
    cyc(0, 3'b101, 0);
    chk("t5_ch_low", 32'(ch_a), 32'd0);
    chk("t5_valid", 32'(valid_a), 32'd1);
    cyc(0, 3'b100, 3'b101);
    chk("t5_proto_kept", 32'(proto_err_a), 32'b100);
    chk("t5_valid_kept", 32'(valid_a), 32'd1);

    // 6: counter saturation, then asynchronous reset mid-task
    do_reset();
    for (int k = 0; k < 5; k++) begin
      cyc(3'b001, 0, 0);
      cyc(0, 3'b001, 0);
    end
    chk("t6_sat_b", 32'(done_b[1:0]), 32'd3);
    chk("t6_done_a", 32'(done_a[7:0]), 32'd5);
    cyc(3'b001, 0, 0);
    cyc(0, 0, 0);
    #3;
    reset = 1'b0;
    #1;
    chk("t6_async_rst", 32'({cfg_err_a, proto_err_a, timeout_a, valid_a, ch_a, irq_a, done_a[7:0]}), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    check_all();

    // Randomized traffic
    timeout = 16'd8;
    for (int n = 0; n < 4000; n++) begin
      rand_cfg();
      if ($urandom_range(0, 5) == 0) begin
        rc = $urandom_range(0, 2);
        rb = ($urandom_range(0, 1) == 1) ? 3 : $urandom_range(0, 63);
        exp_cfg[rc*64 + rb] = ~exp_cfg[rc*64 + rb];
      end
      for (int c = 0; c < 3; c++) begin
        busy[c] = ($urandom_range(0, 9) != 0);
        rs[c]   = ($urandom_range(0, 7) == 0);
        ri[c]   = ($urandom_range(0, 7) == 0);
        rl[c]   = ($urandom_range(0, 15) == 0);
      end
      if ($urandom_range(0, 99) == 0)
        timeout = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(3, 12));
      if ($urandom_range(0, 499) == 0) do_reset();
      cyc(rs, ri, rl);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
